// File: rtl/flow_math_pkg.sv
// flow_math_pkg: shared definitions for the flow_quantizer divider pipeline.
//   - Default widths and depth (lanes, numerator, denominator, stages).
//   - Saturation constants for the signed quotient.
//   - lane_res_t: per-lane state carried between divider stages.
//       quot : dividend/quotient shift register. In the last stage it holds
//              the signed result.
//       rem  : partial remainder.
//       neg  : numerator sign.
//       dz   : divide-by-zero flag.
//   - abs_mag: magnitude of a signed numerator on NUM_W unsigned bits.
//     The most negative numerator maps to 2^(NUM_W-1) without overflow.
// The struct is sized from the default widths, so the lane and denominator
// widths of flow_quantizer follow DEF_NUM_W / DEF_DEN_W.
package flow_math_pkg;

  localparam int DEF_N     = 2;
  localparam int DEF_NUM_W = 16;
  localparam int DEF_DEN_W = 10;
  localparam int DEF_PIPE  = 8;

  localparam logic signed [DEF_NUM_W-1:0] SAT_POS = {1'b0, {(DEF_NUM_W-1){1'b1}}};
  localparam logic signed [DEF_NUM_W-1:0] SAT_NEG = {1'b1, {(DEF_NUM_W-1){1'b0}}};

  typedef struct packed {
    logic [DEF_NUM_W-1:0] quot;
    logic [DEF_DEN_W-1:0] rem;
    logic                 neg;
    logic                 dz;
  } lane_res_t;

  function automatic logic [DEF_NUM_W-1:0] abs_mag(input logic [DEF_NUM_W-1:0] v);
    logic [DEF_NUM_W-1:0] m;
    if (v[DEF_NUM_W-1]) begin
      m = ~v + {{(DEF_NUM_W-1){1'b0}}, 1'b1};
    end else begin
      m = v;
    end
    return m;
  endfunction

endpackage

// File: rtl/flow_div_stage.sv
// flow_div_stage: one restoring-divider stage for one lane.
// Each stage retires BITS quotient bits and then registers the result.
// When LAST is set, the stage also formats the output before the register:
//   - optional rounding,
//   - sign application,
//   - saturation,
//   - divide-by-zero substitution.
// Optional feature: FLOW_QUANTIZER_ROUND_EN enables round-half-away-from-zero
// when i_round is set. Without it the stage always truncates.
// Ports:
//   clk, rst  : clock and asynchronous active-high reset.
//   i_en      : advance enable. When low, the stage holds its value.
//   i_lane    : lane state from the previous stage.
//   i_den     : lane divisor for this stage.
//   i_round   : rounding request carried with the beat.
//   o_lane    : registered lane state.
//   o_den     : registered divisor.
module flow_div_stage
  import flow_math_pkg::*;
#(
  parameter int NUM_W = DEF_NUM_W,
  parameter int DEN_W = DEF_DEN_W,
  parameter int BITS  = 2,
  parameter bit LAST  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  lane_res_t        i_lane,
  input  logic [DEN_W-1:0] i_den,
  input  logic             i_round,
  output lane_res_t        o_lane,
  output logic [DEN_W-1:0] o_den
);

  logic [DEN_W:0]   w_sh;
  logic [NUM_W-1:0] w_q;
  logic [DEN_W-1:0] w_r;
  logic             w_inc;
  logic [NUM_W:0]   w_qr;
  logic [NUM_W-1:0] w_fmt;
  lane_res_t        r_lane;
  logic [DEN_W-1:0] r_den;

  // Restoring division steps.
  // The remainder stays below the divisor, so the shifted value is below
  // 2*den. The difference therefore fits back into DEN_W bits.
  always_comb begin
    w_q  = i_lane.quot;
    w_r  = i_lane.rem;
    w_sh = {(DEN_W+1){1'b0}};
    for (int b = 0; b < BITS; b++) begin
      w_sh = {w_r, w_q[NUM_W-1]};
      w_q  = {w_q[NUM_W-2:0], 1'b0};
      if (w_sh >= {1'b0, i_den}) begin
        w_q[0] = 1'b1;
        w_r    = w_sh[DEN_W-1:0] - i_den;
      end else begin
        w_r    = w_sh[DEN_W-1:0];
      end
    end
  end

`ifdef FLOW_QUANTIZER_ROUND_EN
  // Round half away from zero on the magnitude when 2r >= den.
  always_comb begin
    if (i_round && ({w_r, 1'b0} >= {1'b0, i_den})) begin
      w_inc = 1'b1;
    end else begin
      w_inc = 1'b0;
    end
    w_qr = {1'b0, w_q} + {{NUM_W{1'b0}}, w_inc};
  end
`else
  logic w_unused_round;
  assign w_unused_round = i_round;

  // Truncation only: the magnitude passes straight through.
  always_comb begin
    w_inc = 1'b0;
    w_qr  = {w_inc, w_q};
  end
`endif

  // Apply the sign, then saturate. A divide-by-zero overrides both.
  // A negative magnitude never exceeds 2^(NUM_W-1), so plain negation is exact.
  always_comb begin
    if (i_lane.dz) begin
      w_fmt = i_lane.neg ? SAT_NEG : SAT_POS;
    end else if (i_lane.neg) begin
      w_fmt = ~w_qr[NUM_W-1:0] + {{(NUM_W-1){1'b0}}, 1'b1};
    end else if (w_qr > {1'b0, SAT_POS}) begin
      w_fmt = SAT_POS;
    end else begin
      w_fmt = w_qr[NUM_W-1:0];
    end
  end

  // Stage register. It holds its value while i_en is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lane <= '0;
      r_den  <= {DEN_W{1'b0}};
    end else if (i_en) begin
      r_lane.quot <= LAST ? w_fmt : w_q;
      r_lane.rem  <= w_r;
      r_lane.neg  <= i_lane.neg;
      r_lane.dz   <= i_lane.dz;
      r_den       <= i_den;
    end
  end

  assign o_lane = r_lane;
  assign o_den  = r_den;

endmodule

// File: rtl/flow_quantizer.sv
// flow_quantizer: N-lane pipelined signed divider/quantizer with
// valid/ready flow control.
// The design uses a global stall: the whole pipeline freezes while
// out_valid & ~out_ready.
// Optional feature: FLOW_QUANTIZER_ROUND_EN enables per-beat rounding
// selected by in_round. Without it the design truncates and ignores in_round.
// Ports:
//   clk, rst        : clock and asynchronous active-high reset.
//   in_valid        : input beat present (input).
//   in_ready        : input beat accepted (output).
//   in_data         : N signed numerators.
//   in_denom        : N unsigned divisors.
//   in_round        : 1 = round half away from zero, 0 = truncate.
//   in_eob, in_sob, in_sof : sideband carried with the beat.
//   out_valid       : result beat present (output).
//   out_ready       : downstream accepts the beat (input).
//   out_data        : N signed quotients.
//   out_dz          : per-lane divide-by-zero flags.
//   out_eob, out_sob, out_sof : sideband aligned with out_data.
module flow_quantizer
  import flow_math_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int NUM_W = DEF_NUM_W,
  parameter int DEN_W = DEF_DEN_W,
  parameter int PIPE  = DEF_PIPE
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [N*NUM_W-1:0] in_data,
  input  logic [N*DEN_W-1:0]      in_denom,
  input  logic                    in_round,
  input  logic                    in_eob,
  input  logic                    in_sob,
  input  logic                    in_sof,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [N*NUM_W-1:0] out_data,
  output logic [N-1:0]            out_dz,
  output logic                    out_eob,
  output logic                    out_sob,
  output logic                    out_sof
);

  localparam int BITS = NUM_W / PIPE;

  logic [PIPE-1:0]  r_vld;
  logic [PIPE-1:0]  r_sof;
  logic [PIPE-1:0]  r_sob;
  logic [PIPE-1:0]  r_eob;
  logic             r_rst_done;
  logic             w_stall;
  logic             w_adv;
  logic             w_acc;
  logic [PIPE-1:0]  w_rnd_in;
  lane_res_t        w_res [N][PIPE];
  logic [DEN_W-1:0] w_den [N][PIPE];

  assign w_stall   = r_vld[PIPE-1] & ~out_ready;
  assign w_adv     = ~w_stall;
  assign in_ready  = r_rst_done & ~w_stall;
  assign w_acc     = in_valid & r_rst_done;
  assign out_valid = r_vld[PIPE-1];
  assign out_sof   = r_sof[PIPE-1];
  assign out_sob   = r_sob[PIPE-1];
  assign out_eob   = r_eob[PIPE-1];

  // Hold off input for one cycle after reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rst_done <= 1'b0;
    end else begin
      r_rst_done <= 1'b1;
    end
  end

  // Valid and sideband shift register. It freezes while the output is stalled.
  // Sideband is gated so that bubbles never carry a marker.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld <= {PIPE{1'b0}};
      r_sof <= {PIPE{1'b0}};
      r_sob <= {PIPE{1'b0}};
      r_eob <= {PIPE{1'b0}};
    end else if (w_adv) begin
      r_vld[0] <= w_acc;
      r_sof[0] <= w_acc & in_sof;
      r_sob[0] <= w_acc & in_sob;
      r_eob[0] <= w_acc & in_eob;
      for (int p = 1; p < PIPE; p++) begin
        r_vld[p] <= r_vld[p-1];
        r_sof[p] <= r_sof[p-1];
        r_sob[p] <= r_sob[p-1];
        r_eob[p] <= r_eob[p-1];
      end
    end
  end

`ifdef FLOW_QUANTIZER_ROUND_EN
  logic [PIPE-1:0] r_rnd;
  logic            w_unused_rnd;
  assign w_unused_rnd = r_rnd[PIPE-1];

  // Rounding-mode bit travelling in lockstep with the beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rnd <= {PIPE{1'b0}};
    end else if (w_adv) begin
      r_rnd[0] <= in_round;
      for (int p = 1; p < PIPE; p++) begin
        r_rnd[p] <= r_rnd[p-1];
      end
    end
  end

  // The rounding bit seen at the input of each stage.
  always_comb begin
    w_rnd_in[0] = in_round;
    for (int p = 1; p < PIPE; p++) begin
      w_rnd_in[p] = r_rnd[p-1];
    end
  end
`else
  logic w_unused_rnd;
  assign w_unused_rnd = in_round;
  assign w_rnd_in     = {PIPE{1'b0}};
`endif

  for (genvar l = 0; l < N; l++) begin : g_lane
    logic [NUM_W-1:0] w_num;
    logic [DEN_W-1:0] w_den0;
    lane_res_t        w_head;
    logic             w_unused_tail;

    assign w_num  = in_data[l*NUM_W +: NUM_W];
    assign w_den0 = in_denom[l*DEN_W +: DEN_W];
    assign w_head = '{quot: abs_mag(w_num),
                      rem:  {DEN_W{1'b0}},
                      neg:  w_num[NUM_W-1],
                      dz:   (w_den0 == {DEN_W{1'b0}})};

    assign out_data[l*NUM_W +: NUM_W] = w_res[l][PIPE-1].quot;
    assign out_dz[l]                  = w_res[l][PIPE-1].dz;
    assign w_unused_tail              = ^{w_res[l][PIPE-1].rem, w_den[l][PIPE-1]};

    for (genvar p = 0; p < PIPE; p++) begin : g_stage
      lane_res_t        w_in;
      logic [DEN_W-1:0] w_din;

      if (p == 0) begin : g_first
        assign w_in  = w_head;
        assign w_din = w_den0;
      end else begin : g_next
        assign w_in  = w_res[l][p-1];
        assign w_din = w_den[l][p-1];
      end

      flow_div_stage #(
        .NUM_W (NUM_W),
        .DEN_W (DEN_W),
        .BITS  (BITS),
        .LAST  (p == PIPE-1)
      ) u_stage (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_adv),
        .i_lane  (w_in),
        .i_den   (w_din),
        .i_round (w_rnd_in[p]),
        .o_lane  (w_res[l][p]),
        .o_den   (w_den[l][p])
      );
    end
  end

endmodule
